// File: rtl/rom_4_bit_pkg.sv
// Shared widths, default contents and lookup helper for the 16x4 read-only memory.
package rom_4_bit_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 4;
    localparam int DEPTH_DEF  = 16;

    // Word i sits at bits [i*4 +: 4] and holds 15 - i, so word 0 (0xF) is the low nibble.
    localparam logic [DEPTH_DEF*DATA_W_DEF-1:0] ROM_INIT_DEFAULT = 64'h0123_4567_89AB_CDEF;

    function automatic logic [DATA_W_DEF-1:0] rom_word(
        input logic [DEPTH_DEF*DATA_W_DEF-1:0] table_bits,
        input logic [ADDR_W_DEF-1:0]           addr
    );
        return table_bits[addr*DATA_W_DEF +: DATA_W_DEF];
    endfunction

endpackage

// File: rtl/rom_4_bit.sv
// Fixed-content ROM with a registered read port; reset clears the output word.
module rom_4_bit
    import rom_4_bit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter logic [(2**ADDR_W)*DATA_W-1:0] INIT = ROM_INIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] words [DEPTH];

    // Unpack the flat table once so the read is a plain array index.
    for (genvar i = 0; i < DEPTH; i++) begin : g_unpack
        assign words[i] = INIT[i*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (en) begin
            data <= words[addr];
        end
    end

endmodule

// File: tb/tb_rom_4_bit.sv
// Directed bench for rom_4_bit: default table and a constant 0xA table, checked via scoreboard queues.
module tb_rom_4_bit;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] addr;
    logic [3:0] data_def;
    logic [3:0] data_a;

    int passed;
    int total;

    logic [3:0] q_def [$];
    logic [3:0] q_a   [$];
    logic [3:0] model_a;

    rom_4_bit u_def (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .addr (addr),
        .data (data_def)
    );

    rom_4_bit #(
        .ADDR_W (4),
        .DATA_W (4),
        .INIT   ({16{4'hA}})
    ) u_a (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .addr (addr),
        .data (data_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs, take one edge, and queue the word each instance should show after it.
    task automatic step(input logic r, input logic e, input logic [3:0] a, input logic [3:0] exp);
        rst  = r;
        en   = e;
        addr = a;
        @(posedge clk);
        q_def.push_back(exp);
        if (r) model_a = 4'h0;
        else if (e) model_a = 4'hA;
        q_a.push_back(model_a);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (q_def.size() > 0) check("default_rom", data_def, q_def.pop_front());
        if (q_a.size() > 0) check("const_a_rom", data_a, q_a.pop_front());
    end

    initial begin
        passed  = 0;
        total   = 0;
        model_a = 4'h0;
        rst     = 1'b1;
        en      = 1'b1;
        addr    = 4'h5;

        repeat (4) step(1'b1, 1'b1, 4'h5, 4'h0);

        step(1'b0, 1'b1, 4'h0, 4'hF);
        step(1'b0, 1'b1, 4'h1, 4'hE);
        step(1'b0, 1'b1, 4'h2, 4'hD);

        step(1'b0, 1'b0, 4'h1, 4'hD);
        step(1'b0, 1'b0, 4'h1, 4'hD);
        step(1'b0, 1'b1, 4'hF, 4'h0);

        step(1'b0, 1'b1, 4'h3, 4'hC);
        addr = 4'h7;
        #2;
        check("no_comb_path", data_def, 4'hC);
        step(1'b0, 1'b1, 4'h7, 4'h8);

        for (int k = 0; k < 16; k++) begin
            step(1'b0, 1'b1, 4'(k), 4'(15 - k));
        end

        step(1'b1, 1'b1, 4'h3, 4'h0);
        step(1'b0, 1'b1, 4'h3, 4'hC);

        step(1'b1, 1'b0, 4'h0, 4'h0);
        step(1'b0, 1'b0, 4'h9, 4'h0);
        step(1'b0, 1'b1, 4'hE, 4'h1);

        repeat (2) @(posedge clk);
        #3;
        total++;
        if (q_def.size() == 0 && q_a.size() == 0) begin
            passed++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d/%0d entries left, expected 0/0", q_def.size(), q_a.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rom_4_bit.md
Name: rom_4_bit

Overview:
- Read-only memory with 16 words of 4 bits each and a synchronous, registered read port with a read enable.
- Contents are fixed at elaboration time from a constant table.
- Serves as a small lookup and microcode store in the computer_architecture RAM/ROM group. Readers are clocked logic that sample `data` one cycle after presenting `addr` with `en` high.

Parameters:
- ADDR_W, 4, address width; depth = 2**ADDR_W = 16 words.
- DATA_W, 4, word width in bits.
- INIT, ROM_INIT_DEFAULT (package constant), packed table of 2**ADDR_W words of DATA_W bits; word i sits at bits [i*DATA_W +: DATA_W].

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  read enable; 1 = load the addressed word this edge.
- addr  input  ADDR_W  word address.
- data  output  DATA_W  registered read data.

Behaviour:
- All state changes on the rising edge of clk only. No combinational path from addr or en to data.
- Reset:
  - rst=1 at an edge sets data to 0, regardless of en and addr.
  - rst has priority over en.
  - Reset mid-stream discards the pending read. The first valid read after deassertion needs en=1 at the next edge.
- Read:
  - rst=0 and en=1 at an edge: data <= INIT[addr], visible after that edge.
  - Latency is exactly 1 clock.
  - Back-to-back reads at every edge give a throughput of one word per cycle.
- Hold: rst=0 and en=0 at an edge leaves data unchanged, i.e. the last read word or 0 after reset. addr is ignored while en=0.
- Address range:
  - All 16 addresses are valid, with no wrap or out-of-range case at the default ADDR_W.
  - Depth always equals 2**ADDR_W; no partial-depth tables.
- X handling: if addr contains X/Z while en=1, data is X in simulation. No checking logic is added.
- Default contents: ROM_INIT_DEFAULT[i] = 15 - i, i.e. the bitwise complement of the address.
  - 0x0→0xF, 0x1→0xE, 0x2→0xD, …, 0xF→0x0.
- Contents never change at run time; the block has no write port.
- Timing relative to clk is undefined before the first clock edge. data powers up X in simulation until the first reset or read.

Decomposition:
- Package rom_4_bit_pkg holds:
  - ADDR_W_DEF = 4, DATA_W_DEF = 4, DEPTH_DEF = 16.
  - ROM_INIT_DEFAULT as a packed constant.
  - A pure function rom_word(table, addr) that returns the addressed word.
- No sub-module. The table lookup is a constant-indexed function/case, and one always_ff holds the data register with rst/en priority.

Test Plan:
- Reset: rst=1, en=1, addr=0x5, one edge → data=0x0; hold rst=1 for 3 edges → data stays 0x0.
- Basic read: rst=0, en=1, addr=0x0, edge → data=0xF. addr=0x1, edge → data=0xE. addr=0x2, edge → data=0xD.
- Enable hold: after data=0xD, set en=0 and addr=0x1, 2 edges → data stays 0xD. Then en=1 and addr=0xF, edge → data=0x0.
- Latency check: change addr between edges with en=1 → data must not change until the next rising edge. Also sweep addr 0x0..0xF on consecutive edges → data[k] = 15-k, one cycle late.
- Reset priority: en=1, addr=0x3, rst=1 at the same edge → data=0x0, not 0xC. Next edge with rst=0 and en=1 → data=0xC.
- Custom INIT: instantiate with INIT = {16{4'hA}} → every address reads 0xA with 1-cycle latency.
